// File: rtl/lc3_io_pkg.sv
// Shared constants for the LC-3 memory-mapped keyboard/display channel bank:
// register offsets inside a channel window and status bit positions.
package lc3_io_pkg;

   localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFE00;

   localparam logic [2:0] OFF_KBSR = 3'd0;
   localparam logic [2:0] OFF_KBDR = 3'd2;
   localparam logic [2:0] OFF_DSR  = 3'd4;
   localparam logic [2:0] OFF_DDR  = 3'd6;

   localparam int READY_BIT = 15;
   localparam int IE_BIT    = 14;
   localparam int OVF_BIT   = 13;

   // Odd word offsets alias onto the even register below them.
   function automatic logic [2:0] align_off(input logic [2:0] off);
      return off & 3'b110;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Count-based FIFO with a combinational head. A push while full is accepted
// only if a pop frees the slot in the same cycle; a pop while empty is ignored.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_Clk,
   input  logic             reset_,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_reg[rd_ptr_reg];

   always_ff @(posedge i_Clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; head is only meaningful while not empty.
   always_ff @(posedge i_Clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/lc3_mmio_uart_bank.sv
// Bank of NUM_CH LC-3 keyboard/display register sets, each backed by RX/TX
// FIFOs, decoded from the MAR/MIO_EN/RW path beside the SRAM.
module lc3_mmio_uart_bank
   import lc3_io_pkg::*;
#(
   parameter int          NUM_CH    = 1,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic                  i_Clk,
   input  logic                  reset_,
   input  logic [15:0]           mar,
   input  logic [15:0]           bus,
   input  logic                  mio_en,
   input  logic                  rw,
   output logic                  io_hit,
   output logic [15:0]           rdata,
   output logic                  r,
   input  logic [8*NUM_CH-1:0]   rx_data,
   input  logic [NUM_CH-1:0]     rx_valid,
   output logic [NUM_CH-1:0]     rx_ready,
   output logic [8*NUM_CH-1:0]   tx_data,
   output logic [NUM_CH-1:0]     tx_valid,
   input  logic [NUM_CH-1:0]     tx_ready,
   output logic [NUM_CH-1:0]     irq
);

   localparam logic [16:0] END_ADDR = 17'(BASE_ADDR) + 17'(8 * NUM_CH);

   logic [15:0] off;
   logic [12:0] ch_idx;
   logic [2:0]  reg_off;
   logic        mio_en_q_reg;
   logic        blk_reg;
   logic        r_reg;
   logic        r_next;
   logic [15:0] rdata_reg;
   logic [15:0] rd_mux;
   logic        acc_start;
   logic        io_rd;
   logic        io_wr;
   logic [NUM_CH-1:0] ch_sel;
   logic [15:0] ch_rd [NUM_CH];
   logic        unused_bits;

   assign off     = mar - BASE_ADDR;
   assign ch_idx  = off[15:3];
   assign reg_off = align_off(off[2:0]);
   assign io_hit  = ({1'b0, mar} >= {1'b0, BASE_ADDR}) && ({1'b0, mar} < END_ADDR);

   // blk_reg holds off an access that was already asserted across reset
   // until mio_en has been seen low once.
   assign acc_start = mio_en & ~mio_en_q_reg & ~blk_reg;
   assign io_rd     = acc_start & io_hit & ~rw;
   assign io_wr     = acc_start & io_hit & rw;

   assign unused_bits = ^{bus[15], bus[13:8]};

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic       kb_ie_reg;
         logic       ds_ie_reg;
         logic       ovf_reg;
         logic [7:0] ddr_reg;
         logic       rx_full;
         logic       rx_empty;
         logic [7:0] rx_head;
         logic       tx_full;
         logic       tx_empty;
         logic       kbdr_pop;
         logic       ddr_push;
         logic       tx_pop;

         assign ch_sel[gi] = io_hit & (ch_idx == 13'(gi));
         assign kbdr_pop   = io_rd & ch_sel[gi] & (reg_off == OFF_KBDR);
         assign ddr_push   = io_wr & ch_sel[gi] & (reg_off == OFF_DDR);
         assign tx_pop     = ~tx_empty & tx_ready[gi];

         io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
            .i_Clk (i_Clk),
            .reset_(reset_),
            .push  (rx_valid[gi] & ~rx_full),
            .pop   (kbdr_pop),
            .din   (rx_data[8*gi +: 8]),
            .full  (rx_full),
            .empty (rx_empty),
            .head  (rx_head)
         );

         io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
            .i_Clk (i_Clk),
            .reset_(reset_),
            .push  (ddr_push),
            .pop   (tx_ready[gi]),
            .din   (bus[7:0]),
            .full  (tx_full),
            .empty (tx_empty),
            .head  (tx_data[8*gi +: 8])
         );

         assign rx_ready[gi] = ~rx_full;
         assign tx_valid[gi] = ~tx_empty;
         assign irq[gi]      = (~rx_empty & kb_ie_reg) | (~tx_full & ds_ie_reg);

         always_ff @(posedge i_Clk or negedge reset_) begin
            if (!reset_) begin
               kb_ie_reg <= 1'b0;
               ds_ie_reg <= 1'b0;
               ovf_reg   <= 1'b0;
               ddr_reg   <= 8'h00;
            end else if (io_wr && ch_sel[gi]) begin
               case (reg_off)
                  OFF_KBSR: kb_ie_reg <= bus[IE_BIT];
                  OFF_DSR: begin
                     ds_ie_reg <= bus[IE_BIT];
                     ovf_reg   <= 1'b0;
                  end
                  OFF_DDR: begin
                     ddr_reg <= bus[7:0];
                     // A display pop in the same cycle makes room, so no overflow then.
                     if (tx_full && !tx_pop) ovf_reg <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         always_comb begin
            ch_rd[gi] = 16'h0000;
            case (reg_off)
               OFF_KBSR: begin
                  ch_rd[gi][READY_BIT] = ~rx_empty;
                  ch_rd[gi][IE_BIT]    = kb_ie_reg;
               end
               OFF_KBDR: ch_rd[gi] = rx_empty ? 16'h0000 : {8'h00, rx_head};
               OFF_DSR: begin
                  ch_rd[gi][READY_BIT] = ~tx_full;
                  ch_rd[gi][IE_BIT]    = ds_ie_reg;
                  ch_rd[gi][OVF_BIT]   = ovf_reg;
               end
               default: ch_rd[gi] = {8'h00, ddr_reg};
            endcase
         end
      end
   endgenerate

   always_comb begin
      rd_mux = 16'h0000;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel[c]) rd_mux = rd_mux | ch_rd[c];
      end
   end

   always_comb begin
      r_next = r_reg;
      if (acc_start && io_hit) r_next = 1'b1;
      else if (!mio_en)        r_next = 1'b0;
   end

   always_ff @(posedge i_Clk or negedge reset_) begin
      if (!reset_) begin
         mio_en_q_reg <= 1'b0;
         blk_reg      <= 1'b1;
         r_reg        <= 1'b0;
         rdata_reg    <= 16'h0000;
      end else begin
         mio_en_q_reg <= mio_en;
         blk_reg      <= blk_reg & mio_en;
         r_reg        <= r_next;
         if (io_rd) rdata_reg <= rd_mux;
      end
   end

   assign r     = r_reg;
   assign rdata = rdata_reg;

endmodule

// File: tb/tb_lc3_mmio_uart_bank.sv
// Self-checking bench for lc3_mmio_uart_bank: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_lc3_mmio_uart_bank;

   localparam int NCH   = 2;
   localparam int DEPTH = 4;
   localparam int BASE  = 'hFE00;

   logic              clk;
   logic              reset_;
   logic [15:0]       mar;
   logic [15:0]       bus;
   logic              mio_en;
   logic              rw;
   logic              io_hit;
   logic [15:0]       rdata;
   logic              r;
   logic [8*NCH-1:0]  rx_data;
   logic [NCH-1:0]    rx_valid;
   logic [NCH-1:0]    rx_ready;
   logic [8*NCH-1:0]  tx_data;
   logic [NCH-1:0]    tx_valid;
   logic [NCH-1:0]    tx_ready;
   logic [NCH-1:0]    irq;

   int checks   = 0;
   int failures = 0;

   lc3_mmio_uart_bank #(.NUM_CH(NCH), .DEPTH(DEPTH), .BASE_ADDR(16'hFE00)) dut (
      .i_Clk   (clk),
      .reset_  (reset_),
      .mar     (mar),
      .bus     (bus),
      .mio_en  (mio_en),
      .rw      (rw),
      .io_hit  (io_hit),
      .rdata   (rdata),
      .r       (r),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  rx_buf [NCH][DEPTH];
   logic [7:0]  tx_buf [NCH][DEPTH];
   int          rx_n [NCH];
   int          tx_n [NCH];
   bit          kb_ie [NCH];
   bit          ds_ie [NCH];
   bit          ovf [NCH];
   logic [7:0]  shadow [NCH];
   logic [15:0] m_rdata;
   bit          m_r;
   bit          m_prev;
   bit          m_armed;

   int          ma, rel, ch, rg;
   bit          start, hit;
   int          rxn0 [NCH];
   bit          txp [NCH];
   bit          rxpop [NCH];
   bit          txpush [NCH];
   logic [NCH-1:0] e_rdy, e_val, e_irq;

   always @(negedge clk) begin
      ma  = int'(mar);
      hit = (ma >= BASE) && (ma < BASE + 8*NCH);
      if (!reset_) begin
         for (int c = 0; c < NCH; c++) begin
            rx_n[c] = 0; tx_n[c] = 0; kb_ie[c] = 0; ds_ie[c] = 0; ovf[c] = 0; shadow[c] = 8'h00;
         end
         m_rdata = 16'h0000; m_r = 0; m_prev = 0; m_armed = 0;
         chk("rst_rx_ready", 32'(rx_ready), 32'(2'b11));
         chk("rst_tx_valid", 32'(tx_valid), 32'h0);
         chk("rst_irq", 32'(irq), 32'h0);
         chk("rst_r", 32'(r), 32'h0);
         chk("rst_rdata", 32'(rdata), 32'h0);
      end else begin
         for (int c = 0; c < NCH; c++) begin
            e_rdy[c] = (rx_n[c] < DEPTH);
            e_val[c] = (tx_n[c] > 0);
            e_irq[c] = ((rx_n[c] > 0) && kb_ie[c]) || ((tx_n[c] < DEPTH) && ds_ie[c]);
            if (tx_n[c] > 0) chk("tx_data", 32'(tx_data[8*c +: 8]), 32'(tx_buf[c][0]));
         end
         chk("rx_ready", 32'(rx_ready), 32'(e_rdy));
         chk("tx_valid", 32'(tx_valid), 32'(e_val));
         chk("irq", 32'(irq), 32'(e_irq));
         chk("io_hit", 32'(io_hit), 32'(hit));
         chk("rdata", 32'(rdata), 32'(m_rdata));
         chk("r", 32'(r), 32'(m_r));

         // next state from the inputs that the coming clock edge will sample
         for (int c = 0; c < NCH; c++) begin
            rxn0[c] = rx_n[c];
            txp[c]  = (tx_n[c] > 0) && tx_ready[c];
            rxpop[c] = 0;
            txpush[c] = 0;
         end
         start = mio_en && !m_prev && m_armed;
         if (start && hit) begin
            rel = ma - BASE;
            ch  = rel / 8;
            rg  = (rel % 8) / 2;
            if (!rw) begin
               m_rdata = 16'h0000;
               case (rg)
                  0: begin m_rdata[15] = (rx_n[ch] > 0); m_rdata[14] = kb_ie[ch]; end
                  1: if (rx_n[ch] > 0) begin m_rdata = {8'h00, rx_buf[ch][0]}; rxpop[ch] = 1; end
                  2: begin m_rdata[15] = (tx_n[ch] < DEPTH); m_rdata[14] = ds_ie[ch]; m_rdata[13] = ovf[ch]; end
                  default: m_rdata = {8'h00, shadow[ch]};
               endcase
            end else begin
               case (rg)
                  0: kb_ie[ch] = bus[14];
                  2: begin ds_ie[ch] = bus[14]; ovf[ch] = 0; end
                  3: begin
                     shadow[ch] = bus[7:0];
                     if (tx_n[ch] < DEPTH || txp[ch]) txpush[ch] = 1;
                     else ovf[ch] = 1;
                  end
                  default: ;
               endcase
            end
         end
         if (start && hit) m_r = 1;
         else if (!mio_en) m_r = 0;
         m_armed = m_armed || !mio_en;
         m_prev  = mio_en;

         for (int c = 0; c < NCH; c++) begin
            if (rxpop[c]) begin
               for (int k = 0; k < DEPTH-1; k++) rx_buf[c][k] = rx_buf[c][k+1];
               rx_n[c]--;
            end
            if (rx_valid[c] && rxn0[c] < DEPTH) begin
               rx_buf[c][rx_n[c]] = rx_data[8*c +: 8];
               rx_n[c]++;
            end
            if (txp[c]) begin
               for (int k = 0; k < DEPTH-1; k++) tx_buf[c][k] = tx_buf[c][k+1];
               tx_n[c]--;
            end
            if (txpush[c]) begin
               tx_buf[c][tx_n[c]] = bus[7:0];
               tx_n[c]++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic io_access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                            input int hold, output logic [15:0] rd);
      mar = addr; rw = wr; bus = wdata; mio_en = 1'b1;
      step();
      rd = rdata;
      for (int i = 1; i < hold; i++) step();
      mio_en = 1'b0;
      step();
      $display("access addr=%h rw=%0d wdata=%h rdata=%h", addr, wr, wdata, rd);
      mar = 16'h0000; rw = 1'b0; bus = 16'h0000;
   endtask

   logic [15:0] rd;
   logic [7:0]  got [$];
   int          left;
   int          pick;

   initial begin
      reset_ = 1'b0; mar = 16'h0000; bus = 16'h0000; mio_en = 1'b0; rw = 1'b0;
      rx_data = '0; rx_valid = '0; tx_ready = '0;
      repeat (3) step();
      reset_ = 1'b1;
      step(); step();

      // one byte in, KBSR read held three cycles
      rx_data[7:0] = 8'h41; rx_valid = 2'b01;
      step();
      rx_valid = 2'b00;
      mar = 16'hFE00; rw = 1'b0; mio_en = 1'b1;
      chk("t1_r_before", 32'(r), 32'h0);
      step();
      chk("t1_kbsr", 32'(rdata), 32'h8000);
      chk("t1_r_rise", 32'(r), 32'h1);
      step(); step();
      chk("t1_r_held", 32'(r), 32'h1);
      mio_en = 1'b0;
      step();
      chk("t1_r_drop", 32'(r), 32'h0);

      io_access(16'hFE02, 1'b0, 16'h0, 3, rd);
      chk("t2_kbdr", 32'(rd), 32'h0041);
      io_access(16'hFE00, 1'b0, 16'h0, 3, rd);
      chk("t2_kbsr_empty", 32'(rd), 32'h0000);

      // TX overflow then drain
      for (int i = 0; i < 5; i++) io_access(16'hFE06, 1'b1, 16'(8'h61 + i), 1, rd);
      io_access(16'hFE04, 1'b0, 16'h0, 1, rd);
      chk("t3_dsr_full_ovf", 32'(rd), 32'h2000);
      io_access(16'hFE06, 1'b0, 16'h0, 1, rd);
      chk("t3_ddr_shadow", 32'(rd), 32'h0065);
      tx_ready = 2'b01;
      for (int i = 0; i < 12 && got.size() < 4; i++) begin
         if (tx_valid[0]) got.push_back(tx_data[7:0]);
         step();
      end
      tx_ready = 2'b00;
      chk("t3_stream_len", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size(); i++) chk("t3_stream_byte", 32'(got[i]), 32'(8'h61 + i));
      io_access(16'hFE04, 1'b1, 16'h0000, 1, rd);
      io_access(16'hFE05, 1'b0, 16'h0, 1, rd);
      chk("t3_dsr_cleared", 32'(rd), 32'h8000);

      // channel 1 interrupt
      io_access(16'hFE08, 1'b1, 16'h4000, 1, rd);
      rx_data[15:8] = 8'h5A; rx_valid = 2'b10;
      step();
      rx_valid = 2'b00;
      chk("t4_irq", 32'(irq), 32'(2'b10));
      io_access(16'hFE0A, 1'b0, 16'h0, 2, rd);
      chk("t4_kbdr1", 32'(rd), 32'h005A);
      chk("t4_irq_clear", 32'(irq), 32'h0);
      io_access(16'hFE08, 1'b1, 16'h0000, 1, rd);

      // address window boundaries
      mar = 16'h3000; rw = 1'b0; mio_en = 1'b1;
      #1 chk("t5_hit_3000", 32'(io_hit), 32'h0);
      step();
      chk("t5_r_3000", 32'(r), 32'h0);
      mio_en = 1'b0;
      step();
      mar = 16'hFE10; #1 chk("t5_hit_end", 32'(io_hit), 32'h0);
      mar = 16'hFE0F; #1 chk("t5_hit_last", 32'(io_hit), 32'h1);
      mar = 16'hFDFF; #1 chk("t5_hit_below", 32'(io_hit), 32'h0);
      mar = 16'h0000;
      step();

      // reset in the middle of a KBDR read
      io_access(16'hFE00, 1'b1, 16'h4000, 1, rd);
      rx_valid = 2'b01; rx_data[7:0] = 8'h11;
      step();
      rx_data[7:0] = 8'h22;
      step();
      rx_valid = 2'b00;
      chk("t6_irq_before", 32'(irq), 32'(2'b01));
      mar = 16'hFE02; rw = 1'b0; mio_en = 1'b1;
      step();
      #2 reset_ = 1'b0;
      #1;
      chk("t6_r", 32'(r), 32'h0);
      chk("t6_rx_ready", 32'(rx_ready), 32'(2'b11));
      chk("t6_irq", 32'(irq), 32'h0);
      step(); step();
      reset_ = 1'b1;
      rx_valid = 2'b01; rx_data[7:0] = 8'h77;
      step();
      rx_valid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         chk("t6_no_restart_r", 32'(r), 32'h0);
         step();
      end
      mio_en = 1'b0;
      step();
      io_access(16'hFE00, 1'b0, 16'h0, 1, rd);
      chk("t6_kbsr_after", 32'(rd), 32'h8000);
      io_access(16'hFE02, 1'b0, 16'h0, 1, rd);
      chk("t6_kbdr_after", 32'(rd), 32'h0077);

      // randomized traffic, checked each cycle by the model
      left = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rx_valid = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
         rx_data  = 16'($urandom);
         tx_ready = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
         if (left > 0) begin
            left--;
            if (left == 0) mio_en = 1'b0;
         end else if (!mio_en && ($urandom % 3 == 0)) begin
            pick = int'($urandom % 8);
            if (pick == 0)      mar = 16'($urandom);
            else if (pick == 1) mar = 16'(BASE + 16 + int'($urandom_range(0, 7)));
            else                mar = 16'(BASE + int'($urandom_range(0, 15)));
            rw     = 1'($urandom);
            bus    = 16'($urandom);
            mio_en = 1'b1;
            left   = int'($urandom_range(1, 3));
         end
         if (cyc == 1500) begin
            reset_ = 1'b0;
            step(); step();
            reset_ = 1'b1;
         end
         step();
      end
      mio_en = 1'b0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
